// File: rtl/ram_pg_ctrl.sv
`default_nettype none

//------------------------------------------------------------------------------
// Module      : ram_pg_ctrl
// Description : Power-gate controller and re-initialiser for one power-gated
//               2R1W RAM. Owns the RAM write port and pwrGate, quiesces the
//               RAM before gating, and after waking rewrites every entry with
//               the configured reset pattern before reporting ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module ram_pg_ctrl #(
  parameter int          DEPTH        = 64,
  parameter int          INDEX        = 6,
  parameter int          WIDTH        = 32,
  parameter int          RESET_VAL    = `RAM_RESET_ZERO,
  parameter int unsigned SEQ_START    = 0,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          WAKE_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gateReq_i,
  input  logic             clientWe_i,
  input  logic [INDEX-1:0] clientAddr_i,
  input  logic [WIDTH-1:0] clientData_i,
  output logic             pwrGate_o,
  output logic             we_o,
  output logic [INDEX-1:0] addrWr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ready_o
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_ACTIVE = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_GATED  = 3'd3;
  localparam logic [2:0] ST_WAKE   = 3'd4;

  // Any pattern other than ZERO or SEQ means contents are never rewritten.
  localparam bit DO_INIT = (RESET_VAL == `RAM_RESET_ZERO) ||
                           (RESET_VAL == `RAM_RESET_SEQ);

  localparam logic [2:0]       ST_RESET   = DO_INIT ? ST_INIT : ST_ACTIVE;
  localparam logic [2:0]       ST_POSTWK  = DO_INIT ? ST_INIT : ST_ACTIVE;
  localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       WAKE_LAST  = 8'(WAKE_CYCLES - 1);
  localparam logic [INDEX-1:0] IDX_LAST   = INDEX'(DEPTH - 1);

  logic [2:0]       state;
  logic [7:0]       cnt;
  logic [INDEX-1:0] idx;
  logic [WIDTH-1:0] init_data;

  // Data written during re-initialisation, selected once at elaboration.
  generate
    if (RESET_VAL == `RAM_RESET_SEQ) begin : g_seq_init
      localparam logic [WIDTH-1:0] SEQ_BASE = WIDTH'(SEQ_START);
      assign init_data = SEQ_BASE + WIDTH'(idx);
    end else begin : g_zero_init
      assign init_data = '0;
    end
  endgenerate

  // Write-port mux: init engine in INIT, client in ACTIVE, idle otherwise.
  always_comb begin
    we_o     = 1'b0;
    addrWr_o = '0;
    data_o   = '0;
    case (state)
      ST_INIT: begin
        we_o     = 1'b1;
        addrWr_o = idx;
        data_o   = init_data;
      end
      ST_ACTIVE: begin
        we_o     = clientWe_i;
        addrWr_o = clientAddr_i;
        data_o   = clientData_i;
      end
      default: begin
        we_o     = 1'b0;
        addrWr_o = '0;
        data_o   = '0;
      end
    endcase
  end

  // Power-state sequencer; pwrGate and ready are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RESET;
      cnt       <= 8'd0;
      idx       <= '0;
      pwrGate_o <= 1'b0;
      ready_o   <= !DO_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          // Client writes and gate requests wait until ACTIVE.
          if (idx == IDX_LAST) begin
            state   <= ST_ACTIVE;
            idx     <= '0;
            ready_o <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (gateReq_i) begin
            state   <= ST_DRAIN;
            ready_o <= 1'b0;
            cnt     <= 8'd0;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt + 8'd1;
          if (!gateReq_i) begin
            // Request withdrawn before gating: contents are still intact.
            state   <= ST_ACTIVE;
            ready_o <= 1'b1;
          end else if (cnt == DRAIN_LAST) begin
            state     <= ST_GATED;
            pwrGate_o <= 1'b1;
          end
        end
        ST_GATED: begin
          if (!gateReq_i) begin
            state     <= ST_WAKE;
            pwrGate_o <= 1'b0;
            cnt       <= 8'd0;
          end
        end
        ST_WAKE: begin
          cnt <= cnt + 8'd1;
          if (gateReq_i) begin
            // Re-gating during settle skips the (pointless) init pass.
            state     <= ST_GATED;
            pwrGate_o <= 1'b1;
          end else if (cnt == WAKE_LAST) begin
            state   <= ST_POSTWK;
            idx     <= '0;
            ready_o <= !DO_INIT;
          end
        end
        default: begin
          state     <= ST_RESET;
          cnt       <= 8'd0;
          idx       <= '0;
          pwrGate_o <= 1'b0;
          ready_o   <= !DO_INIT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_pg_ctrl.sv
`default_nettype none

//------------------------------------------------------------------------------
// Module      : tb_ram_pg_ctrl
// Description : Scoreboard bench for ram_pg_ctrl. Expected RAM writes are
//               queued by the stimulus; monitors pop and compare on every
//               write the DUTs present. Timing of ready/pwrGate is checked
//               directly against hand-computed cycle counts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef RAM_RESET_ZERO
`define RAM_RESET_ZERO 0
`endif
`ifndef RAM_RESET_SEQ
`define RAM_RESET_SEQ 1
`endif

module tb_ram_pg_ctrl;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // ZERO-pattern DUT (exercised)
  logic        gate_z = 1'b0, cwe_z = 1'b0;
  logic [5:0]  caddr_z = '0;
  logic [31:0] cdata_z = '0;
  logic        pwr_z, we_z, ready_z;
  logic [5:0]  addr_z;
  logic [31:0] data_z;

  // SEQ-pattern DUT and no-init DUT (idle inputs)
  logic        idle_b = 1'b0;
  logic [5:0]  idle_a = '0;
  logic [31:0] idle_d = '0;
  logic        pwr_s, we_s, ready_s;
  logic [5:0]  addr_s;
  logic [31:0] data_s;
  logic        pwr_n, we_n, ready_n;
  logic [5:0]  addr_n;
  logic [31:0] data_n;

  wr_t         q_z[$];
  wr_t         q_s[$];
  logic [31:0] ram_z [64];
  logic [31:0] ram_s [64];

  int vectors = 0;
  int miscompares = 0;

  ram_pg_ctrl dut_z (
    .clk(clk), .reset(reset), .gateReq_i(gate_z), .clientWe_i(cwe_z),
    .clientAddr_i(caddr_z), .clientData_i(cdata_z), .pwrGate_o(pwr_z),
    .we_o(we_z), .addrWr_o(addr_z), .data_o(data_z), .ready_o(ready_z)
  );

  ram_pg_ctrl #(.RESET_VAL(`RAM_RESET_SEQ), .SEQ_START(32)) dut_s (
    .clk(clk), .reset(reset), .gateReq_i(idle_b), .clientWe_i(idle_b),
    .clientAddr_i(idle_a), .clientData_i(idle_d), .pwrGate_o(pwr_s),
    .we_o(we_s), .addrWr_o(addr_s), .data_o(data_s), .ready_o(ready_s)
  );

  ram_pg_ctrl #(.RESET_VAL(7)) dut_n (
    .clk(clk), .reset(reset), .gateReq_i(idle_b), .clientWe_i(idle_b),
    .clientAddr_i(idle_a), .clientData_i(idle_d), .pwrGate_o(pwr_n),
    .we_o(we_n), .addrWr_o(addr_n), .data_o(data_n), .ready_o(ready_n)
  );

  always #5 clk = ~clk;

  // Monitor: every presented write must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (we_z) begin
        vectors++;
        if (q_z.size() == 0) begin
          miscompares++;
          $display("FAIL z_write: got addr=%0d data=%h, expected no write", addr_z, data_z);
        end else begin
          wr_t e;
          e = q_z.pop_front();
          if (e.addr !== addr_z || e.data !== data_z) begin
            miscompares++;
            $display("FAIL z_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     addr_z, data_z, e.addr, e.data);
          end
        end
        ram_z[addr_z] = data_z;
      end
      if (we_s) begin
        vectors++;
        if (q_s.size() == 0) begin
          miscompares++;
          $display("FAIL s_write: got addr=%0d data=%h, expected no write", addr_s, data_s);
        end else begin
          wr_t e;
          e = q_s.pop_front();
          if (e.addr !== addr_s || e.data !== data_s) begin
            miscompares++;
            $display("FAIL s_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     addr_s, data_s, e.addr, e.data);
          end
        end
        ram_s[addr_s] = data_s;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_z(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 6'(a);
    e.data = d;
    q_z.push_back(e);
  endtask

  task automatic push_s(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 6'(a);
    e.data = d;
    q_s.push_back(e);
  endtask

  // Full init pass for both DUTs: ZERO writes 0, SEQ writes 32+i.
  task automatic push_init_both();
    for (int i = 0; i < 64; i++) begin
      push_z(i, 32'd0);
      push_s(i, 32'(32 + i));
    end
  endtask

  task automatic wait_ready_z(input logic val, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ready_z !== val && n < 300);
  endtask

  task automatic wait_gate_z(input logic val, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pwr_z !== val && n < 300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nz;
    for (int i = 0; i < 64; i++) begin
      ram_z[i] = 32'hA5A5A5A5;
      ram_s[i] = 32'hA5A5A5A5;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwr", 32'(pwr_z), 32'd0);
    chk("rst_ready", 32'(ready_z), 32'd0);
    chk("rst_we_init", 32'(we_z), 32'd1);
    chk("rst_addr", 32'(addr_z), 32'd0);
    chk("rst_noinit_ready", 32'(ready_n), 32'd1);
    chk("rst_noinit_we", 32'(we_n), 32'd0);

    // Release; client write during INIT must be dropped
    push_init_both();
    reset   = 1'b1;
    cwe_z   = 1'b1;
    caddr_z = 6'd7;
    cdata_z = 32'hBEEF;
    wait_ready_z(1'b1, n);
    cwe_z = 1'b0;
    chk("init_ready_cycles", 32'(n), 32'd64);
    chk("seq_ready", 32'(ready_s), 32'd1);
    nz = 0;
    for (int i = 0; i < 64; i++) if (ram_z[i] !== 32'd0) nz++;
    chk("zero_ram_nonzero", 32'(nz), 32'd0);
    chk("seq_ram5", ram_s[5], 32'd37);
    chk("seq_ram63", ram_s[63], 32'd95);

    // Write addr 3 and request gating in the same cycle
    cwe_z = 1'b1; caddr_z = 6'd3; cdata_z = 32'hDEAD; gate_z = 1'b1;
    push_z(3, 32'hDEAD);
    @(posedge clk); #1;
    cwe_z = 1'b0;
    chk("drain_ready", 32'(ready_z), 32'd0);
    chk("drain_pwr", 32'(pwr_z), 32'd0);
    wait_gate_z(1'b1, n);
    chk("gate_latency_after_first", 32'(n), 32'd2);

    // Wake with full re-init
    for (int i = 0; i < 64; i++) push_z(i, 32'd0);
    gate_z = 1'b0;
    @(posedge clk); #1;
    chk("wake_pwr", 32'(pwr_z), 32'd0);
    wait_ready_z(1'b1, n);
    chk("wake_ready_after_first", 32'(n), 32'd68);
    chk("wake_ram3", ram_z[3], 32'd0);

    // Abort drain in its second cycle
    cwe_z = 1'b1; caddr_z = 6'd3; cdata_z = 32'hDEAD;
    push_z(3, 32'hDEAD);
    @(posedge clk); #1;
    cwe_z = 1'b0; gate_z = 1'b1;
    @(posedge clk); #1;
    chk("abort_drain_ready0", 32'(ready_z), 32'd0);
    @(posedge clk); #1;
    chk("abort_drain_pwr_mid", 32'(pwr_z), 32'd0);
    gate_z = 1'b0;
    @(posedge clk); #1;
    chk("abort_drain_ready1", 32'(ready_z), 32'd1);
    chk("abort_drain_pwr", 32'(pwr_z), 32'd0);
    chk("abort_drain_ram3", ram_z[3], 32'hDEAD);

    // Gate, then abort wake in its second cycle
    gate_z = 1'b1;
    wait_gate_z(1'b1, n);
    chk("gate_latency", 32'(n), 32'd3);
    gate_z = 1'b0;
    @(posedge clk); #1;
    chk("abort_wake_pwr0", 32'(pwr_z), 32'd0);
    @(posedge clk); #1;
    gate_z = 1'b1;
    @(posedge clk); #1;
    chk("abort_wake_pwr1", 32'(pwr_z), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_wake_ready", 32'(ready_z), 32'd0);

    // Wake and reset mid-INIT at idx 20 with a client write pending
    for (int i = 0; i < 20; i++) push_z(i, 32'd0);
    gate_z = 1'b0;
    cwe_z = 1'b1; caddr_z = 6'd9; cdata_z = 32'h1111;
    repeat (25) @(posedge clk);
    #1;
    chk("midinit_addr", 32'(addr_z), 32'd20);
    reset = 1'b0;
    #1;
    chk("midinit_rst_pwr", 32'(pwr_z), 32'd0);
    chk("midinit_rst_ready", 32'(ready_z), 32'd0);
    chk("midinit_rst_addr", 32'(addr_z), 32'd0);
    push_init_both();
    @(posedge clk); #1;
    reset = 1'b1;
    wait_ready_z(1'b1, n);
    cwe_z = 1'b0;
    chk("reinit_ready_cycles", 32'(n), 32'd64);
    chk("reinit_ram9", ram_z[9], 32'd0);

    // Reset while gated drops pwrGate asynchronously
    gate_z = 1'b1;
    wait_gate_z(1'b1, n);
    chk("gate_latency2", 32'(n), 32'd3);
    reset = 1'b0;
    #1;
    chk("gated_rst_pwr", 32'(pwr_z), 32'd0);
    chk("gated_rst_ready", 32'(ready_z), 32'd0);
    push_init_both();
    @(posedge clk); #1;
    gate_z = 1'b0;
    reset = 1'b1;
    wait_ready_z(1'b1, n);
    chk("gated_reinit_cycles", 32'(n), 32'd64);

    repeat (2) @(posedge clk);
    #1;
    chk("z_queue_left", 32'(q_z.size()), 32'd0);
    chk("s_queue_left", 32'(q_s.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
